// File: rtl/usbSerialInterfaceEngine.sv
// ============================================================================
// usbSerialInterfaceEngine : shared USB SIE constants and types
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package usbSerialInterfaceEngine;

   localparam int FS_OVER_SAMPLE_RATE = 4;
   localparam int LS_OVER_SAMPLE_RATE = 32;
   localparam int TX_ACTIVE_HOLD      = 8;
   localparam int TX_FIFO_DEPTH       = 4;

   localparam logic [1:0] SE0      = 2'b00;
   localparam logic [1:0] ONE_ZERO = 2'b10;
   localparam logic [1:0] ZERO_ONE = 2'b01;

   typedef struct packed {
      logic       ctrl;
      logic [1:0] bits;
   } txWord_t;

   // Terminal value of the bit-period counter for the selected rate.
   function automatic logic [4:0] bitPeriodLast(input logic fullSpeed);
      return fullSpeed ? 5'(FS_OVER_SAMPLE_RATE - 1) : 5'(LS_OVER_SAMPLE_RATE - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/usb_tx_fifo4.sv
// ============================================================================
// usb_tx_fifo4 : 4-entry FIFO of {ctrl, bits} words for the USB wire driver
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_tx_fifo4
   import usbSerialInterfaceEngine::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  txWord_t dataIn,
   output txWord_t dataOut,
   output logic    full,
   output logic    empty
);

   txWord_t    r_mem [TX_FIFO_DEPTH];
   logic [1:0] r_wrIdx;
   logic [1:0] r_rdIdx;
   logic [2:0] r_count;
   logic       w_doPush;
   logic       w_doPop;

   // Both flags come from the registered count, so a word written into an
   // empty FIFO cannot be popped on the same edge.
   assign full     = (r_count == 3'(TX_FIFO_DEPTH));
   assign empty    = (r_count == 3'd0);
   assign w_doPush = push && !full;
   assign w_doPop  = pop && !empty;
   assign dataOut  = r_mem[r_rdIdx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrIdx <= 2'd0;
         r_rdIdx <= 2'd0;
         r_count <= 3'd0;
         for (int i = 0; i < TX_FIFO_DEPTH; i++) begin
            r_mem[i] <= {1'b0, SE0};
         end
      end else begin
         if (w_doPush) begin
            r_mem[r_wrIdx] <= dataIn;
            r_wrIdx        <= r_wrIdx + 2'd1;
         end
         if (w_doPop) begin
            r_rdIdx <= r_rdIdx + 2'd1;
         end
         r_count <= r_count + {2'b00, w_doPush} - {2'b00, w_doPop};
      end
   end

endmodule

`default_nettype wire

// File: rtl/write_usb_wire_data.sv
// ============================================================================
// write_usb_wire_data : paces SIE line states onto the USB wire, one per bit
// period. Define WRITE_USB_WIRE_LOW_SPEED_EN to honour fullSpeedRate=0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module write_usb_wire_data
   import usbSerialInterfaceEngine::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] TxBitsIn,
   input  logic       TxCtrlIn,
   input  logic       SIETxWEn,
   output logic       SIETxRdy,
   input  logic       fullSpeedRate,
   output logic [1:0] TxBitsOut,
   output logic       TxCtrlOut,
   output logic       TxWireActiveDrive,
   output logic       TxDataOutTick
);

   logic       w_full;
   logic       w_empty;
   logic       w_fs;
   logic       w_rateChange;
   logic       w_tick;
   txWord_t    w_head;
   logic [4:0] r_bitCnt;
   logic [3:0] r_holdCnt;

`ifdef WRITE_USB_WIRE_LOW_SPEED_EN
   logic r_fsRate;

   // A rate switch restarts the bit period so the next tick lands a full
   // period of the new rate later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsRate <= 1'b1;
      end else begin
         r_fsRate <= fullSpeedRate;
      end
   end

   assign w_fs         = fullSpeedRate;
   assign w_rateChange = (r_fsRate != fullSpeedRate);
`else
   logic w_unusedRate;

   assign w_unusedRate = fullSpeedRate;
   assign w_fs         = 1'b1;
   assign w_rateChange = 1'b0;
`endif

   assign w_tick            = !w_rateChange && (r_bitCnt == bitPeriodLast(w_fs));
   assign SIETxRdy          = !w_full;
   assign TxWireActiveDrive = TxCtrlOut || (r_holdCnt != 4'd0);

   usb_tx_fifo4 u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (SIETxWEn),
      .pop     (w_tick),
      .dataIn  ({TxCtrlIn, TxBitsIn}),
      .dataOut (w_head),
      .full    (w_full),
      .empty   (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitCnt      <= 5'd0;
         r_holdCnt     <= 4'd0;
         TxBitsOut     <= ONE_ZERO;
         TxCtrlOut     <= 1'b0;
         TxDataOutTick <= 1'b0;
      end else begin
         if (w_rateChange || w_tick) begin
            r_bitCnt <= 5'd0;
         end else begin
            r_bitCnt <= r_bitCnt + 5'd1;
         end

         if (w_tick) begin
            TxDataOutTick <= !TxDataOutTick;
            if (!w_empty) begin
               {TxCtrlOut, TxBitsOut} <= w_head;
            end else begin
               TxCtrlOut <= 1'b0;
               TxBitsOut <= w_fs ? ONE_ZERO : ZERO_ONE;
            end
         end

         // Reloaded every driven cycle, so the window counts from the fall.
         if (TxCtrlOut) begin
            r_holdCnt <= 4'(TX_ACTIVE_HOLD);
         end else if (r_holdCnt != 4'd0) begin
            r_holdCnt <= r_holdCnt - 4'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_write_usb_wire_data.sv
// ============================================================================
// tb_write_usb_wire_data : directed self-checking bench for write_usb_wire_data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_write_usb_wire_data;

   logic       clk           = 1'b0;
   logic       rst           = 1'b1;
   logic [1:0] TxBitsIn      = 2'b00;
   logic       TxCtrlIn      = 1'b0;
   logic       SIETxWEn      = 1'b0;
   logic       fullSpeedRate = 1'b1;
   logic       SIETxRdy;
   logic [1:0] TxBitsOut;
   logic       TxCtrlOut;
   logic       TxWireActiveDrive;
   logic       TxDataOutTick;

   int nCmp = 0;
   int nBad = 0;

   always #5 clk = ~clk;

   write_usb_wire_data dut (
      .clk               (clk),
      .rst               (rst),
      .TxBitsIn          (TxBitsIn),
      .TxCtrlIn          (TxCtrlIn),
      .SIETxWEn          (SIETxWEn),
      .SIETxRdy          (SIETxRdy),
      .fullSpeedRate     (fullSpeedRate),
      .TxBitsOut         (TxBitsOut),
      .TxCtrlOut         (TxCtrlOut),
      .TxWireActiveDrive (TxWireActiveDrive),
      .TxDataOutTick     (TxDataOutTick)
   );

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Holds the strobe through one active edge; caller clears SIETxWEn.
   task automatic strobe(input logic c, input logic [1:0] b);
      SIETxWEn = 1'b1;
      TxCtrlIn = c;
      TxBitsIn = b;
      sync();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_val(input logic [2:0] v, input int budget, output bit found, output int cnt);
      found = 1'b0;
      cnt   = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ({TxCtrlOut, TxBitsOut} === v) begin
            found = 1'b1;
            cnt   = i + 1;
            break;
         end
      end
   endtask

   // Called at a negedge showing v; returns at the first negedge showing something else.
   task automatic run_len(input logic [2:0] v, output int len);
      len = 0;
      while ({TxCtrlOut, TxBitsOut} === v && len < 200) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic tick_interval(output int n);
      logic p;
      p = TxDataOutTick;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (TxDataOutTick === p && n < 100);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nCmp++; if (TxBitsOut !== 2'b10) begin nBad++; $display("FAIL reset_bits: got %b expected 10", TxBitsOut); end
      nCmp++; if (TxCtrlOut !== 1'b0) begin nBad++; $display("FAIL reset_ctrl: got %b expected 0", TxCtrlOut); end
      nCmp++; if (TxWireActiveDrive !== 1'b0) begin nBad++; $display("FAIL reset_active: got %b expected 0", TxWireActiveDrive); end
      nCmp++; if (TxDataOutTick !== 1'b0) begin nBad++; $display("FAIL reset_tick: got %b expected 0", TxDataOutTick); end
      nCmp++; if (SIETxRdy !== 1'b1) begin nBad++; $display("FAIL reset_rdy: got %b expected 1", SIETxRdy); end
      sync();
      rst = 1'b0;
      idle(6);
   endtask

   task automatic test_tick_period(input int expected);
      int n;
      tick_interval(n);
      for (int k = 0; k < 2; k++) begin
         tick_interval(n);
         nCmp++; if (n !== expected) begin nBad++; $display("FAIL tick_period: got %0d clk expected %0d", n, expected); end
      end
   endtask

   task automatic test_back_to_back();
      bit found;
      int cnt;
      int len;
      idle(12);
      sync();
      strobe(1'b1, 2'b10);
      strobe(1'b1, 2'b01);
      strobe(1'b1, 2'b00);
      SIETxWEn = 1'b0;
      wait_val(3'b110, 12, found, cnt);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL b2b_start: got timeout expected 110 on wire"); end
      run_len(3'b110, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL b2b_bit0_len: got %0d expected 4", len); end
      run_len(3'b101, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL b2b_bit1_len: got %0d expected 4", len); end
      run_len(3'b100, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL b2b_bit2_len: got %0d expected 4", len); end
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b010) begin nBad++; $display("FAIL b2b_idle: got %b expected 010", {TxCtrlOut, TxBitsOut}); end
   endtask

   task automatic test_latency();
      bit found;
      int lat;
      idle(12);
      sync();
      strobe(1'b1, 2'b01);
      SIETxWEn = 1'b0;
      wait_val(3'b101, 12, found, lat);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL latency_seen: got timeout expected 101 on wire"); end
      nCmp++; if (lat < 2 || lat > 5) begin nBad++; $display("FAIL latency_bound: got %0d clk expected 2..5", lat); end
   endtask

   // Four writes land between two pop ticks; the fifth strobe meets a full FIFO.
   task automatic test_overflow();
      int n;
      int len;
      idle(12);
      tick_interval(n);
      repeat (3) @(posedge clk);
      #1;
      strobe(1'b1, 2'b10);
      strobe(1'b1, 2'b01);
      strobe(1'b1, 2'b11);
      strobe(1'b1, 2'b00);
      TxCtrlIn = 1'b0;
      TxBitsIn = 2'b00;
      @(negedge clk);
      nCmp++; if (SIETxRdy !== 1'b0) begin nBad++; $display("FAIL ovf_rdy_full: got %b expected 0", SIETxRdy); end
      sync();
      SIETxWEn = 1'b0;
      TxCtrlIn = 1'b0;
      TxBitsIn = 2'b00;
      @(negedge clk);
      nCmp++; if (SIETxRdy !== 1'b1) begin nBad++; $display("FAIL ovf_rdy_after_pop: got %b expected 1", SIETxRdy); end
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b110) begin nBad++; $display("FAIL ovf_first: got %b expected 110", {TxCtrlOut, TxBitsOut}); end
      run_len(3'b110, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL ovf_len_a: got %0d expected 4", len); end
      run_len(3'b101, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL ovf_len_b: got %0d expected 4", len); end
      run_len(3'b111, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL ovf_len_c: got %0d expected 4", len); end
      run_len(3'b100, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL ovf_len_d: got %0d expected 4", len); end
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b010) begin nBad++; $display("FAIL ovf_dropped: got %b expected 010", {TxCtrlOut, TxBitsOut}); end
   endtask

   task automatic test_active_hold();
      bit found;
      int cnt;
      int len;
      int n;
      int lowSeen;
      idle(12);
      nCmp++; if (TxWireActiveDrive !== 1'b0) begin nBad++; $display("FAIL hold_idle: got %b expected 0", TxWireActiveDrive); end
      sync();
      strobe(1'b1, 2'b10);
      strobe(1'b0, 2'b10);
      strobe(1'b1, 2'b01);
      SIETxWEn = 1'b0;
      wait_val(3'b110, 12, found, cnt);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL hold_start: got timeout expected 110 on wire"); end
      run_len(3'b110, len);
      n = 0;
      lowSeen = 0;
      while ({TxCtrlOut, TxBitsOut} === 3'b010 && n < 50) begin
         if (TxWireActiveDrive !== 1'b1) lowSeen++;
         n++;
         @(negedge clk);
      end
      nCmp++; if (n !== 4) begin nBad++; $display("FAIL hold_gap_len: got %0d expected 4", n); end
      nCmp++; if (lowSeen !== 0) begin nBad++; $display("FAIL hold_redrive: got %0d low cycles expected 0", lowSeen); end
      run_len(3'b101, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL hold_last_len: got %0d expected 4", len); end
      n = 0;
      while (TxWireActiveDrive === 1'b1 && TxCtrlOut === 1'b0 && n < 50) begin
         n++;
         @(negedge clk);
      end
      nCmp++; if (n !== 8) begin nBad++; $display("FAIL hold_window: got %0d clk expected 8", n); end
      nCmp++; if (TxWireActiveDrive !== 1'b0) begin nBad++; $display("FAIL hold_release: got %b expected 0", TxWireActiveDrive); end
   endtask

   task automatic test_reset_mid_packet();
      bit found;
      int cnt;
      int driven;
      idle(12);
      sync();
      strobe(1'b1, 2'b01);
      strobe(1'b1, 2'b11);
      strobe(1'b1, 2'b00);
      SIETxWEn = 1'b0;
      wait_val(3'b101, 12, found, cnt);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL rstmid_start: got timeout expected 101 on wire"); end
      sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      nCmp++; if (TxCtrlOut !== 1'b0) begin nBad++; $display("FAIL rstmid_ctrl: got %b expected 0", TxCtrlOut); end
      nCmp++; if (TxBitsOut !== 2'b10) begin nBad++; $display("FAIL rstmid_bits: got %b expected 10", TxBitsOut); end
      nCmp++; if (SIETxRdy !== 1'b1) begin nBad++; $display("FAIL rstmid_rdy: got %b expected 1", SIETxRdy); end
      nCmp++; if (TxWireActiveDrive !== 1'b0) begin nBad++; $display("FAIL rstmid_active: got %b expected 0", TxWireActiveDrive); end
      driven = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (TxCtrlOut !== 1'b0) driven++;
      end
      nCmp++; if (driven !== 0) begin nBad++; $display("FAIL rstmid_no_more_bits: got %0d driven clk expected 0", driven); end
   endtask

`ifdef WRITE_USB_WIRE_LOW_SPEED_EN
   task automatic test_low_speed();
      bit found;
      int cnt;
      int len;
      idle(12);
      sync();
      fullSpeedRate = 1'b0;
      idle(40);
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b001) begin nBad++; $display("FAIL ls_idle: got %b expected 001", {TxCtrlOut, TxBitsOut}); end
      test_tick_period(32);
      sync();
      strobe(1'b1, 2'b01);
      SIETxWEn = 1'b0;
      wait_val(3'b101, 40, found, cnt);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL ls_start: got timeout expected 101 on wire"); end
      run_len(3'b101, len);
      nCmp++; if (len !== 32) begin nBad++; $display("FAIL ls_bit_len: got %0d expected 32", len); end
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b001) begin nBad++; $display("FAIL ls_underrun: got %b expected 001", {TxCtrlOut, TxBitsOut}); end
   endtask

   // Switch lands two edges after a pop; the held bit then spans the change edge plus 32 clk.
   task automatic test_rate_change();
      bit found;
      int cnt;
      int len;
      sync();
      fullSpeedRate = 1'b1;
      idle(80);
      sync();
      strobe(1'b1, 2'b10);
      strobe(1'b1, 2'b11);
      strobe(1'b1, 2'b00);
      SIETxWEn = 1'b0;
      wait_val(3'b110, 12, found, cnt);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL rate_start: got timeout expected 110 on wire"); end
      sync();
      fullSpeedRate = 1'b0;
      @(negedge clk);
      run_len(3'b110, len);
      nCmp++; if (len !== 33) begin nBad++; $display("FAIL rate_switch_len: got %0d expected 33", len); end
      run_len(3'b111, len);
      nCmp++; if (len !== 32) begin nBad++; $display("FAIL rate_bit1_len: got %0d expected 32", len); end
      run_len(3'b100, len);
      nCmp++; if (len !== 32) begin nBad++; $display("FAIL rate_bit2_len: got %0d expected 32", len); end
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b001) begin nBad++; $display("FAIL rate_idle: got %b expected 001", {TxCtrlOut, TxBitsOut}); end
   endtask
`else
   task automatic test_rate_ignored();
      bit found;
      int cnt;
      int len;
      idle(12);
      sync();
      fullSpeedRate = 1'b0;
      strobe(1'b1, 2'b10);
      strobe(1'b1, 2'b11);
      SIETxWEn = 1'b0;
      wait_val(3'b110, 12, found, cnt);
      nCmp++; if (found !== 1'b1) begin nBad++; $display("FAIL ign_start: got timeout expected 110 on wire"); end
      run_len(3'b110, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL ign_bit0_len: got %0d expected 4", len); end
      run_len(3'b111, len);
      nCmp++; if (len !== 4) begin nBad++; $display("FAIL ign_bit1_len: got %0d expected 4", len); end
      nCmp++; if ({TxCtrlOut, TxBitsOut} !== 3'b010) begin nBad++; $display("FAIL ign_idle: got %b expected 010", {TxCtrlOut, TxBitsOut}); end
      test_tick_period(4);
      fullSpeedRate = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_tick_period(4);
      test_back_to_back();
      test_latency();
      test_overflow();
      test_active_hold();
      test_reset_mid_packet();
`ifdef WRITE_USB_WIRE_LOW_SPEED_EN
      test_low_speed();
      test_rate_change();
`else
      test_rate_ignored();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
